dcache_assoc: RTL and testbench
===============================

DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 addr_width, 16, address bit width.
REQ-002 line_width, 64, cache line bit width.
REQ-003 depth, 64, number of sets; power of two, >= 2.
REQ-004 ways, 2, associativity; power of two, 1..8.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset; asynchronous, active-high.
REQ-007 addr_i  in  addr_width  request address; set = addr_i[set_width-1:0], tag = remaining upper bits.
REQ-008 ready_o  out  1  requests accepted this cycle when high.
REQ-009 r_valid_i  in  1  read request.
REQ-010 r_valid_o  out  1  read result valid, one cycle after accepted read.
REQ-011 r_miss_o  out  1  read result was a miss; qualified by r_valid_o.
REQ-012 read_o  out  line_width  read line data; qualified by r_valid_o && !r_miss_o.
REQ-013 w_valid_i  in  1  write (fill or store) request.
REQ-014 dirty_i  in  1  line being written is dirty.
REQ-015 write_i  in  line_width  line data to write.
REQ-016 ejected_valid_o  out  1  dirty victim line pending write-back.
REQ-017 ejected_ready_i  in  1  downstream accepts ejected line.
REQ-018 ejected_addr_o  out  addr_width  victim address, {victim tag, set}.
REQ-019 ejected_o  out  line_width  victim line data.

Function
REQ-020 Request accepted only when ready_o && (r_valid_i || w_valid_i); requests while ready_o low are ignored, no state change.
REQ-021 ready_o = !(ejected_valid_o && !ejected_ready_i).
REQ-022 Read: hit if any way of the set is valid with matching tag; r_valid_o/r_miss_o/read_o registered, latency exactly 1 cycle; reads do not change replacement state.
REQ-023 Multiple matching ways impossible by construction; write never creates a duplicate tag in a set.
REQ-024 Write hit (valid, tag match): overwrite that way; new dirty = dirty_i | old dirty; no ejection.
REQ-025 Write miss victim: lowest-index invalid way; else way at the set's round-robin pointer, which then increments modulo ways.
REQ-026 Write miss on valid dirty victim: next cycle ejected_valid_o=1 with victim tag/set/data; held stable until ejected_ready_i sampled high.
REQ-027 Write miss on clean or invalid victim: no ejection; victim line silently replaced.
REQ-028 Read and write in same accepted cycle: both performed; read returns pre-write contents; write follows REQ-024..027.
REQ-029 Ejection accepted same cycle as a new write ejecting: new ejection replaces old one (ready_o high permits this); no line lost.
REQ-030 ways=1: degenerates to direct-mapped; round-robin pointer absent.

Reset
REQ-031 On rst_i: all valid bits 0, all round-robin pointers 0, r_valid_o=0, r_miss_o=0, ejected_valid_o=0, ready_o=1.
REQ-032 Data, tag and dirty arrays not reset; read_o/ejected data undefined until written.
REQ-033 Reset during pending ejection discards it; ejected_valid_o low in the cycle rst_i asserts.

Structure
REQ-034 Package dcache_pkg holds the dcache_line_s declaration macro and a lowest-set-bit priority function used for invalid-way selection.
REQ-035 Sub-module dcache_way: one way's data/tag/dirty/valid storage, registered read, tag compare; instantiated ways times.
REQ-036 Top level holds round-robin pointers, victim mux, ejection register and handshake.

Verification (depth=4, ways=2, addr_width=8, line_width=16)
REQ-037 Reset, read 0x05 -> r_valid_o=1, r_miss_o=1 next cycle; no ejection.
REQ-038 Write 0x05 data 0xAAAA clean, read 0x05 -> hit, read_o=0xAAAA, latency 1.
REQ-039 Write dirty 0x01, 0x05, then clean 0x09 -> ejected_valid_o=1, addr 0x01, data of 0x01; 0x05 still hits.
REQ-040 Hold ejected_ready_i=0 3 cycles -> ready_o=0, ejection stable, concurrent reads ignored; ready_i=1 -> ready_o=1 next cycle.
REQ-041 Write dirty 0x05 then clean 0x05 -> no ejection; later eviction of 0x05 ejects it (dirty retained).
REQ-042 Assert rst_i mid-ejection -> ejected_valid_o=0 immediately; read 0x05 misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared line-record macro and way-selection helper for dcache_assoc.
package dcache_pkg;

  // Record for a line leaving the cache: owning tag, its set and the line data.
  `define DCACHE_LINE_S(TAG_W, SET_W, LINE_W) \
    typedef struct packed { \
      logic [(TAG_W)-1:0]  tag; \
      logic [(SET_W)-1:0]  set_idx; \
      logic [(LINE_W)-1:0] data; \
    } dcache_line_s;

  localparam int unsigned MAX_WAYS  = 8;
  localparam int unsigned MAX_WAY_W = 3;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [MAX_WAY_W-1:0] lowest_set(input logic [MAX_WAYS-1:0] vec);
    logic [MAX_WAY_W-1:0] idx;
    idx = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_WAY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// dcache_way: one way of the cache -- valid/dirty/tag/data per set, tag compare, registered read.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int unsigned line_width = 64,
  parameter int unsigned depth      = 64,
  parameter int unsigned set_w      = 6,
  parameter int unsigned tag_w      = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [set_w-1:0]      set_idx,
  input  logic [tag_w-1:0]      req_tag,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic                  wr_dirty,
  input  logic [line_width-1:0] wr_data,
  output logic                  hit_c,
  output logic                  valid_c,
  output logic                  dirty_c,
  output logic [tag_w-1:0]      tag_c,
  output logic [line_width-1:0] data_c,
  output logic [line_width-1:0] rd_data
);

  logic [depth-1:0]      valid_q;
  logic [depth-1:0]      dirty_q;
  logic [tag_w-1:0]      tag_q  [depth];
  logic [line_width-1:0] data_q [depth];

  assign valid_c = valid_q[set_idx];
  assign dirty_c = dirty_q[set_idx];
  assign tag_c   = tag_q[set_idx];
  assign data_c  = data_q[set_idx];
  assign hit_c   = valid_q[set_idx] && (tag_q[set_idx] == req_tag);

  // Valid bits are the only reset storage; a write always leaves its line valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  // Line payload storage, left uninitialised.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      dirty_q[set_idx] <= wr_dirty;
      tag_q[set_idx]   <= req_tag;
      data_q[set_idx]  <= wr_data;
    end
  end

  // Registered read, zeroed on a miss so the ways can be OR-combined.
  always_ff @(posedge clk_i) begin
    if (rd_en) begin
      rd_data <= hit_c ? data_q[set_idx] : '0;
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: set-associative line cache with round-robin replacement and dirty-victim ejection.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int unsigned addr_width = 16,
  parameter int unsigned line_width = 64,
  parameter int unsigned depth      = 64,
  parameter int unsigned ways       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [addr_width-1:0] addr_i,
  output logic                  ready_o,
  input  logic                  r_valid_i,
  output logic                  r_valid_o,
  output logic                  r_miss_o,
  output logic [line_width-1:0] read_o,
  input  logic                  w_valid_i,
  input  logic                  dirty_i,
  input  logic [line_width-1:0] write_i,
  output logic                  ejected_valid_o,
  input  logic                  ejected_ready_i,
  output logic [addr_width-1:0] ejected_addr_o,
  output logic [line_width-1:0] ejected_o
);

  localparam int unsigned set_w = $clog2(depth);
  localparam int unsigned tag_w = addr_width - set_w;
  localparam int unsigned way_w = (ways > 1) ? $clog2(ways) : 1;

  `DCACHE_LINE_S(tag_w, set_w, line_width)

  logic [set_w-1:0]      set_idx;
  logic [tag_w-1:0]      req_tag;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [ways-1:0]       hit_vec;
  logic [ways-1:0]       valid_vec;
  logic [ways-1:0]       dirty_vec;
  logic [ways-1:0]       inv_vec;
  logic [ways-1:0]       wr_en_vec;
  logic [tag_w-1:0]      way_tag  [ways];
  logic [line_width-1:0] way_data [ways];
  logic [line_width-1:0] way_rd   [ways];
  logic                  any_hit;
  logic                  any_inv;
  logic [way_w-1:0]      hit_way;
  logic [way_w-1:0]      inv_way;
  logic [way_w-1:0]      rr_way;
  logic [way_w-1:0]      sel_way;
  logic                  wr_dirty;
  logic                  rr_advance;
  logic                  evict_c;
  dcache_line_s          ej_q;

  assign set_idx = addr_i[set_w-1:0];
  assign req_tag = addr_i[addr_width-1:set_w];
  assign ready_o = !(ejected_valid_o && !ejected_ready_i);
  assign rd_acc  = ready_o && r_valid_i;
  assign wr_acc  = ready_o && w_valid_i;
  assign inv_vec = ~valid_vec;

  for (genvar i = 0; i < ways; i++) begin : g_way
    dcache_way #(
      .line_width (line_width),
      .depth      (depth),
      .set_w      (set_w),
      .tag_w      (tag_w)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .set_idx  (set_idx),
      .req_tag  (req_tag),
      .rd_en    (rd_acc),
      .wr_en    (wr_en_vec[i]),
      .wr_dirty (wr_dirty),
      .wr_data  (write_i),
      .hit_c    (hit_vec[i]),
      .valid_c  (valid_vec[i]),
      .dirty_c  (dirty_vec[i]),
      .tag_c    (way_tag[i]),
      .data_c   (way_data[i]),
      .rd_data  (way_rd[i])
    );
  end

  // Way selection: hit way, else lowest invalid way, else the round-robin victim.
  always_comb begin
    wr_en_vec  = '0;
    any_hit    = |hit_vec;
    any_inv    = |inv_vec;
    hit_way    = way_w'(lowest_set(MAX_WAYS'(hit_vec)));
    inv_way    = way_w'(lowest_set(MAX_WAYS'(inv_vec)));
    sel_way    = any_hit ? hit_way : (any_inv ? inv_way : rr_way);
    wr_dirty   = dirty_i | (any_hit & dirty_vec[sel_way]);
    rr_advance = wr_acc && !any_hit && !any_inv;
    evict_c    = rr_advance && dirty_vec[sel_way];
    for (int i = 0; i < ways; i++) begin
      wr_en_vec[i] = wr_acc && (sel_way == way_w'(i));
    end
  end

  if (ways > 1) begin : g_rr
    logic [way_w-1:0] rr_q [depth];

    assign rr_way = rr_q[set_idx];

    // Per-set pointer moves on only when it supplied the victim; wraps naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s < depth; s++) rr_q[s] <= '0;
      end else if (rr_advance) begin
        rr_q[set_idx] <= rr_q[set_idx] + way_w'(1);
      end
    end
  end else begin : g_no_rr
    assign rr_way = '0;
  end

  // Read response flags, one cycle after acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_o <= 1'b0;
      r_miss_o  <= 1'b0;
    end else begin
      r_valid_o <= rd_acc;
      r_miss_o  <= rd_acc && !any_hit;
    end
  end

  // Only the hitting way holds non-zero read data.
  always_comb begin
    read_o = '0;
    for (int i = 0; i < ways; i++) read_o = read_o | way_rd[i];
  end

  // Ejection valid: a new dirty eviction overrides a concurrent handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ejected_valid_o <= 1'b0;
    end else if (evict_c) begin
      ejected_valid_o <= 1'b1;
    end else if (ejected_ready_i) begin
      ejected_valid_o <= 1'b0;
    end
  end

  // Capture the victim before the write overwrites it.
  always_ff @(posedge clk_i) begin
    if (evict_c) begin
      ej_q.tag     <= way_tag[sel_way];
      ej_q.set_idx <= set_idx;
      ej_q.data    <= way_data[sel_way];
    end
  end

  assign ejected_addr_o = {ej_q.tag, ej_q.set_idx};
  assign ejected_o      = ej_q.data;

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed scenarios plus random traffic against a behavioural cache model.
module tb_dcache_assoc;

  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WAYS  = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [AW-1:0] addr_i = '0;
  logic          ready_o;
  logic          r_valid_i = 1'b0;
  logic          r_valid_o;
  logic          r_miss_o;
  logic [LW-1:0] read_o;
  logic          w_valid_i = 1'b0;
  logic          dirty_i = 1'b0;
  logic [LW-1:0] write_i = '0;
  logic          ejected_valid_o;
  logic          ejected_ready_i = 1'b0;
  logic [AW-1:0] ejected_addr_o;
  logic [LW-1:0] ejected_o;

  always #5 clk_i = ~clk_i;

  dcache_assoc #(
    .addr_width (AW),
    .line_width (LW),
    .depth      (DEPTH),
    .ways       (WAYS)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .addr_i          (addr_i),
    .ready_o         (ready_o),
    .r_valid_i       (r_valid_i),
    .r_valid_o       (r_valid_o),
    .r_miss_o        (r_miss_o),
    .read_o          (read_o),
    .w_valid_i       (w_valid_i),
    .dirty_i         (dirty_i),
    .write_i         (write_i),
    .ejected_valid_o (ejected_valid_o),
    .ejected_ready_i (ejected_ready_i),
    .ejected_addr_o  (ejected_addr_o),
    .ejected_o       (ejected_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: contents of every set as a small table of lines.
  bit            m_valid [DEPTH][WAYS];
  bit            m_dirty [DEPTH][WAYS];
  int            m_tag   [DEPTH][WAYS];
  logic [LW-1:0] m_data  [DEPTH][WAYS];
  int            m_rr    [DEPTH];
  bit            e_rv, e_miss, e_ejv;
  logic [LW-1:0] e_read, e_ejdata;
  logic [AW-1:0] e_ejaddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < DEPTH; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
    e_rv = 1'b0;
    e_miss = 1'b0;
    e_ejv = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit w, input logic [AW-1:0] a,
                            input bit d, input logic [LW-1:0] data, input bit ejr);
    int s, t, hw, vic;
    bit rdy;
    s = int'(a) % DEPTH;
    t = int'(a) / DEPTH;
    rdy = !(e_ejv && !ejr);
    e_rv = 1'b0;
    e_miss = 1'b0;
    if (rdy && r) begin
      e_rv = 1'b1;
      e_miss = 1'b1;
      for (int k = 0; k < WAYS; k++) begin
        if (m_valid[s][k] && m_tag[s][k] == t) begin
          e_miss = 1'b0;
          e_read = m_data[s][k];
        end
      end
    end
    if (e_ejv && ejr) e_ejv = 1'b0;
    if (rdy && w) begin
      hw = -1;
      for (int k = 0; k < WAYS; k++) if (m_valid[s][k] && m_tag[s][k] == t) hw = k;
      if (hw >= 0) begin
        m_data[s][hw]  = data;
        m_dirty[s][hw] = m_dirty[s][hw] | d;
      end else begin
        vic = -1;
        for (int k = WAYS - 1; k >= 0; k--) if (!m_valid[s][k]) vic = k;
        if (vic < 0) begin
          vic = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % WAYS;
          if (m_dirty[s][vic]) begin
            e_ejv = 1'b1;
            e_ejaddr = AW'(m_tag[s][vic] * DEPTH + s);
            e_ejdata = m_data[s][vic];
          end
        end
        m_valid[s][vic] = 1'b1;
        m_tag[s][vic]   = t;
        m_data[s][vic]  = data;
        m_dirty[s][vic] = d;
      end
    end
  endtask

  // Compare all meaningful DUT outputs against the model.
  task automatic compare();
    check("r_valid_o", 32'(r_valid_o), 32'(e_rv));
    if (e_rv) check("r_miss_o", 32'(r_miss_o), 32'(e_miss));
    if (e_rv && !e_miss) check("read_o", 32'(read_o), 32'(e_read));
    check("ejected_valid_o", 32'(ejected_valid_o), 32'(e_ejv));
    if (e_ejv) begin
      check("ejected_addr_o", 32'(ejected_addr_o), 32'(e_ejaddr));
      check("ejected_o", 32'(ejected_o), 32'(e_ejdata));
    end
  endtask

  // One clock: drive, check ready, advance model, sample after the edge.
  task automatic cyc(input bit r, input bit w, input logic [AW-1:0] a,
                     input bit d, input logic [LW-1:0] data, input bit ejr);
    r_valid_i = r;
    w_valid_i = w;
    addr_i = a;
    dirty_i = d;
    write_i = data;
    ejected_ready_i = ejr;
    #1;
    check("ready_o", 32'(ready_o), 32'(!(e_ejv && !ejr)));
    model_step(r, w, a, d, data, ejr);
    @(posedge clk_i);
    #1;
    compare();
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    r_valid_i = 1'b0;
    w_valid_i = 1'b0;
    ejected_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    model_reset();
    check("rst_ejected_valid_now", 32'(ejected_valid_o), 32'd0);
    check("rst_ready_now", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_r_valid", 32'(r_valid_o), 32'd0);
    check("reset_ejected_valid", 32'(ejected_valid_o), 32'd0);
    rst_i = 1'b0;

    // Cold read misses.
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 16'h0, 1'b0);
    check("cold_r_valid", 32'(r_valid_o), 32'd1);
    check("cold_r_miss", 32'(r_miss_o), 32'd1);
    check("cold_no_eject", 32'(ejected_valid_o), 32'd0);

    // Fill then hit with one-cycle latency.
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 16'hAAAA, 1'b0);
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 16'h0, 1'b0);
    check("hit_r_miss", 32'(r_miss_o), 32'd0);
    check("hit_read", 32'(read_o), 32'h0000AAAA);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0);
    check("hit_single_pulse", 32'(r_valid_o), 32'd0);

    // Same-cycle read and write returns the pre-write line.
    cyc(1'b1, 1'b1, 8'h05, 1'b0, 16'hBBBB, 1'b0);
    check("rw_pre_write", 32'(read_o), 32'h0000AAAA);
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 16'h0, 1'b0);
    check("rw_post_write", 32'(read_o), 32'h0000BBBB);

    // Dirty eviction of the round-robin victim.
    do_reset();
    cyc(1'b0, 1'b1, 8'h01, 1'b1, 16'h1111, 1'b0);
    cyc(1'b0, 1'b1, 8'h05, 1'b1, 16'h5555, 1'b0);
    cyc(1'b0, 1'b1, 8'h09, 1'b0, 16'h9999, 1'b0);
    check("evict_valid", 32'(ejected_valid_o), 32'd1);
    check("evict_addr", 32'(ejected_addr_o), 32'h01);
    check("evict_data", 32'(ejected_o), 32'h1111);

    // Back-pressure stalls requests and holds the ejection.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h05, 1'b0, 16'h0, 1'b0);
      check("stall_ready", 32'(ready_o), 32'd0);
      check("stall_read_ignored", 32'(r_valid_o), 32'd0);
      check("stall_addr_stable", 32'(ejected_addr_o), 32'h01);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
    check("drain_ready", 32'(ready_o), 32'd1);
    check("drain_valid", 32'(ejected_valid_o), 32'd0);
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 16'h0, 1'b0);
    check("survivor_hit", 32'(r_miss_o), 32'd0);
    check("survivor_data", 32'(read_o), 32'h5555);

    // Dirty bit sticks across a clean overwrite; later eviction ejects it.
    cyc(1'b0, 1'b1, 8'h05, 1'b1, 16'h5A5A, 1'b0);
    check("dirty_hit_no_eject", 32'(ejected_valid_o), 32'd0);
    cyc(1'b0, 1'b1, 8'h05, 1'b0, 16'hA5A5, 1'b0);
    check("clean_hit_no_eject", 32'(ejected_valid_o), 32'd0);
    cyc(1'b0, 1'b1, 8'h0D, 1'b0, 16'hDDDD, 1'b0);
    check("sticky_evict_valid", 32'(ejected_valid_o), 32'd1);
    check("sticky_evict_addr", 32'(ejected_addr_o), 32'h05);
    check("sticky_evict_data", 32'(ejected_o), 32'hA5A5);

    // Reset during a pending ejection discards it and invalidates lines.
    do_reset();
    cyc(1'b1, 1'b0, 8'h05, 1'b0, 16'h0, 1'b0);
    check("post_reset_miss", 32'(r_miss_o), 32'd1);

    // Ejection drained in the same cycle a new one is created.
    cyc(1'b0, 1'b1, 8'h01, 1'b1, 16'h0101, 1'b0);
    cyc(1'b0, 1'b1, 8'h05, 1'b1, 16'h0505, 1'b0);
    cyc(1'b0, 1'b1, 8'h09, 1'b1, 16'h0909, 1'b0);
    cyc(1'b0, 1'b1, 8'h0D, 1'b0, 16'h0D0D, 1'b1);
    check("replace_valid", 32'(ejected_valid_o), 32'd1);
    check("replace_addr", 32'(ejected_addr_o), 32'h05);
    check("replace_data", 32'(ejected_o), 32'h0505);

    // Random traffic over a few tags per set to force conflicts.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            LW'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
